// File: rtl/elevator_car_controller.sv
// Car-side controller. It latches floor calls, steps the car one floor at a time under a travel timer,
// and opens the door when the car reaches a called floor. It executes the moves that the direction calculator requests.
module elevator_car_controller #(
    parameter int FLOOR_BITS    = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2**FLOOR_BITS-1:0]   call_req,
    input  logic                       direction,
    input  logic                       should_move,
    output logic [2**FLOOR_BITS-1:0]   floors_called,
    output logic [FLOOR_BITS-1:0]      current_floor,
    output logic                       moving,
    output logic                       door_open,
    output logic                       arrived
);

    localparam int NUM_FLOORS = 2**FLOOR_BITS;
    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0]    TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_BITS-1:0] TOP_FLOOR   = '1;
    localparam logic [NUM_FLOORS-1:0] FLOOR_ONE   = NUM_FLOORS'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVING = 2'd1;
    localparam logic [1:0] ST_ARRIVE = 2'd2;
    localparam logic [1:0] ST_DOOR   = 2'd3;

    logic [1:0]            r_state;
    logic [FLOOR_BITS-1:0] r_floor;
    logic [NUM_FLOORS-1:0] r_called;
    logic [TIMER_W-1:0]    r_timer;
    logic                  r_dir;

    logic [1:0]            w_state_next;
    logic [FLOOR_BITS-1:0] w_floor_next;
    logic [NUM_FLOORS-1:0] w_called_next;
    logic [NUM_FLOORS-1:0] w_clear_mask;
    logic [TIMER_W-1:0]    w_timer_next;
    logic                  w_dir_next;
    logic                  w_clear;
    logic                  w_here_called;
    logic                  w_move_ok;

    assign w_here_called = r_called[r_floor];
    // A request that would drive the car past either end of the shaft is ignored.
    assign w_move_ok = should_move
                    && !(direction  && (r_floor == TOP_FLOOR))
                    && !(!direction && (r_floor == '0));

    // NOTE: every signal gets a default first so that no path through the case infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_floor_next = r_floor;
        w_timer_next = r_timer;
        w_dir_next   = r_dir;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE, ST_ARRIVE: begin
                if (w_here_called) begin
                    w_state_next = ST_DOOR;
                    w_clear      = 1'b1;
                    w_timer_next = DOOR_LOAD;
                end else if (w_move_ok) begin
                    w_state_next = ST_MOVING;
                    w_dir_next   = direction;
                    w_timer_next = TRAVEL_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MOVING: begin
                if (r_timer == '0) begin
                    w_floor_next = r_dir ? r_floor + 1'b1 : r_floor - 1'b1;
                    w_state_next = ST_ARRIVE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            ST_DOOR: begin
                // Calls for the floor the door is open at are absorbed without touching the timer.
                w_clear = 1'b1;
                if (r_timer == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_timer_next = r_timer - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_clear_mask  = w_clear ? (FLOOR_ONE << r_floor) : '0;
    assign w_called_next = (r_called | call_req) & ~w_clear_mask;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_floor  <= '0;
            r_called <= '0;
            r_timer  <= '0;
            r_dir    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_floor  <= w_floor_next;
            r_called <= w_called_next;
            r_timer  <= w_timer_next;
            r_dir    <= w_dir_next;
        end
    end

    assign floors_called = r_called;
    assign current_floor = r_floor;
    assign moving        = (r_state == ST_MOVING);
    assign door_open     = (r_state == ST_DOOR);
    assign arrived       = (r_state == ST_ARRIVE);

endmodule
